// File: rtl/nucleo_classificador.sv
// nucleo_classificador: hashes a window of cache-line addresses into a bitmap and scores it against cluster signatures.
// Optional HASH_DADOS_EN folds the line data into the hash index as well.
module nucleo_classificador #(
    parameter int NUM_CLUSTERS     = 5,
    parameter int AMPLITUDE_HASH   = 256,
    parameter int TAMANHO_JANELA   = 10,
    parameter int TAMANHO_ENDERECO = 64,
    parameter int LARGURA_LINHA    = 512,
    localparam int H  = $clog2(AMPLITUDE_HASH),
    localparam int CW = $clog2(NUM_CLUSTERS) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LARGURA_LINHA-1:0]    linha_cache,
    input  logic [TAMANHO_ENDERECO-1:0] endereco,
    input  logic                        entrada_valida,
    output logic                        trava,
    input  logic                        cfg_we,
    input  logic [CW-1:0]               cfg_cluster,
    input  logic [AMPLITUDE_HASH-1:0]   cfg_assinatura,
    output logic                        resultado_valido,
    output logic [CW-1:0]               resultado_cluster,
    output logic [H:0]                  resultado_pontos
);
    localparam int LA    = TAMANHO_ENDERECO - 6;
    localparam int NA    = (LA + H - 1) / H;
    localparam int CNT_W = $clog2(TAMANHO_JANELA + 1);

    typedef enum logic [1:0] {COLETA, PONTUA, EMITE} estado_t;

    estado_t                   estado_q, estado_d;
    logic [AMPLITUDE_HASH-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CW-1:0]             k_q, k_d, best_q, best_d, res_c_q, res_c_d;
    logic [H:0]                best_pts_q, best_pts_d, res_p_q, res_p_d;
    logic [AMPLITUDE_HASH-1:0] sig_q [NUM_CLUSTERS];
    logic [AMPLITUDE_HASH-1:0] sig_sel, mask;
    logic [NA*H-1:0]           la_pad;
    logic [H-1:0]              idx;
    logic [H:0]                pts;
    logic                      aceita, upd;

`ifdef HASH_DADOS_EN
    localparam int ND = (LARGURA_LINHA + H - 1) / H;
    logic [ND*H-1:0] dados_pad;
    logic            unused_bits;
    assign unused_bits = ^endereco[5:0];
`else
    logic unused_bits;
    assign unused_bits = ^{linha_cache, endereco[5:0]};
`endif

    always_comb begin
        la_pad = (NA*H)'(endereco[TAMANHO_ENDERECO-1:6]);
        idx    = '0;
        for (int c = 0; c < NA; c++) idx ^= la_pad[c*H +: H];
`ifdef HASH_DADOS_EN
        dados_pad = (ND*H)'(linha_cache);
        for (int c = 0; c < ND; c++) idx ^= dados_pad[c*H +: H];
`endif
    end

    always_comb begin
        sig_sel = '0;
        for (int c = 0; c < NUM_CLUSTERS; c++) if (k_q == CW'(c)) sig_sel = sig_q[c];
        mask = bitmap_q & sig_sel;
        pts  = '0;
        for (int i = 0; i < AMPLITUDE_HASH; i++) pts += (H+1)'(mask[i]);
    end

    assign aceita           = entrada_valida && estado_q == COLETA;
    assign upd              = k_q == '0 || pts > best_pts_q;
    assign trava            = estado_q != COLETA;
    assign resultado_valido = estado_q == EMITE;
    assign resultado_cluster = res_c_q;
    assign resultado_pontos  = res_p_q;

    always_comb begin
        estado_d   = estado_q;
        bitmap_d   = bitmap_q;
        count_d    = count_q;
        k_d        = k_q;
        best_d     = best_q;
        best_pts_d = best_pts_q;
        res_c_d    = res_c_q;
        res_p_d    = res_p_q;
        case (estado_q)
            COLETA: if (aceita) begin
                bitmap_d[idx] = 1'b1;
                count_d       = count_q + 1'b1;
                if (count_q == CNT_W'(TAMANHO_JANELA - 1)) begin
                    estado_d   = PONTUA;
                    k_d        = '0;
                    best_d     = '0;
                    best_pts_d = '0;
                end
            end
            PONTUA: begin
                best_d     = upd ? k_q : best_q;
                best_pts_d = upd ? pts : best_pts_q;
                k_d        = k_q + 1'b1;
                // Final candidate is latched straight into the result so EMITE can present it.
                if (k_q == CW'(NUM_CLUSTERS - 1)) begin
                    estado_d = EMITE;
                    res_c_d  = best_d;
                    res_p_d  = best_pts_d;
                end
            end
            EMITE: begin
                bitmap_d = '0;
                count_d  = '0;
                estado_d = COLETA;
            end
            default: estado_d = COLETA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= COLETA;
            bitmap_q   <= '0;
            count_q    <= '0;
            k_q        <= '0;
            best_q     <= '0;
            best_pts_q <= '0;
            res_c_q    <= '0;
            res_p_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            bitmap_q   <= bitmap_d;
            count_q    <= count_d;
            k_q        <= k_d;
            best_q     <= best_d;
            best_pts_q <= best_pts_d;
            res_c_q    <= res_c_d;
            res_p_q    <= res_p_d;
        end
    end

    // Signatures are frozen outside COLETA so a score never mixes old and new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLUSTERS; c++) sig_q[c] <= '0;
        end else if (cfg_we && estado_q == COLETA) begin
            for (int c = 0; c < NUM_CLUSTERS; c++)
                if (cfg_cluster == CW'(c)) sig_q[c] <= cfg_assinatura;
        end
    end
endmodule
